// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: sequences the five MIPS pipeline stages (IF/ID/EXE/MEM/WB).
// A four-state FSM (boot, run, memory wait, halt) plus combinational hazard
// handling produces a reset/enable pair for every stage register. The stage
// controls respond in the same cycle as the hazard inputs. State, counters and
// the sticky timeout flag are registered.
module pipe_stage_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 4,  // cycles all stages stay in reset after rst falls (1..15)
  parameter int unsigned MEM_WAIT_MAX = 8   // wait cycles without mem_ack before timeout (1..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        debug_en,
  input  logic        debug_step,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [1:0]  ctrl_state
);

  // The encoding is visible on ctrl_state, so the values are fixed.
  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Per-stage control bundle. Bit order in each vector: [4]=IF [3]=ID
  // [2]=EXE [1]=MEM [0]=WB.
  typedef struct packed {
    logic [4:0] en;
    logic [4:0] rst;
  } stage_ctrl_t;

  localparam int unsigned B_IF  = 4;
  localparam int unsigned B_ID  = 3;
  localparam int unsigned B_EXE = 2;
  localparam int unsigned B_MEM = 1;
  localparam int unsigned B_WB  = 0;

  // Named output patterns.
  localparam stage_ctrl_t CTRL_ALL_RST  = '{en: 5'b00000, rst: 5'b11111};
  localparam stage_ctrl_t CTRL_FREEZE   = '{en: 5'b00000, rst: 5'b00000};
  localparam stage_ctrl_t CTRL_ADVANCE  = '{en: 5'b11111, rst: 5'b00000};
  // Memory stall: everything holds, WB clocks in a bubble so the stalled
  // instruction does not write the register file twice.
  localparam stage_ctrl_t CTRL_MEM_WAIT = '{en: 5'b00001, rst: 5'b00001};
  // Load-use: IF/ID hold, a bubble enters EXE, older instructions drain.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{en: 5'b00111, rst: 5'b00100};
  // Taken branch: everything advances (IF loads the target) but the
  // wrong-path instruction entering ID is squashed.
  localparam stage_ctrl_t CTRL_BRANCH   = '{en: 5'b11111, rst: 5'b01000};

  localparam logic [3:0]  BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0]  WAIT_LAST  = 8'(MEM_WAIT_MAX);
  localparam logic [15:0] STALL_SAT  = 16'hFFFF;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_boot_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;
  logic [15:0] r_stall_cnt;

  stage_ctrl_t w_issue_ctrl;   // outcome of the hazard rules when memory is not stalling
  logic        w_issue_stall;  // the hazard rules produced a stall cycle
  stage_ctrl_t w_ctrl;         // final stage controls
  logic        w_stall;        // this cycle counts as a stall cycle
  logic        w_wait_start;   // entering MEM_WAIT from RUN
  logic        w_wait_inc;     // another MEM_WAIT cycle without mem_ack
  logic        w_timeout_set;  // wait budget exhausted

  // Hazard resolution shared by RUN and the completing MEM_WAIT cycle:
  // load-use beats branch, so the branch re-evaluates with forwarded data.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    w_issue_ctrl  = CTRL_ADVANCE;
    w_issue_stall = 1'b0;
    if (load_use_hazard) begin
      w_issue_ctrl  = CTRL_LOAD_USE;
      w_issue_stall = 1'b1;
    end else if (branch_taken) begin
      w_issue_ctrl  = CTRL_BRANCH;
    end
  end

  // Next-state and stage-control decode; rst overrides the outputs in the
  // same cycle so a mid-operation reset clears the whole pipe immediately.
  always_comb begin
    w_next_state  = r_state;
    w_ctrl        = CTRL_FREEZE;
    w_stall       = 1'b0;
    w_wait_start  = 1'b0;
    w_wait_inc    = 1'b0;
    w_timeout_set = 1'b0;

    unique case (r_state)
      ST_BOOT: begin
        w_ctrl = CTRL_ALL_RST;
        if (r_boot_cnt == BOOT_LAST) begin
          w_next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          w_ctrl       = CTRL_MEM_WAIT;
          w_stall      = 1'b1;
          w_wait_start = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else if (debug_en && !debug_step) begin
          // Single-step hold: not a hazard, so not counted as a stall.
          w_ctrl = CTRL_FREEZE;
        end else begin
          w_ctrl  = w_issue_ctrl;
          w_stall = w_issue_stall;
        end
      end

      ST_MEM_WAIT: begin
        // Debug is ignored here: an outstanding access must complete.
        if (!mem_ack) begin
          w_ctrl  = CTRL_MEM_WAIT;
          w_stall = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_timeout_set = 1'b1;
            w_next_state  = ST_HALT;
          end else begin
            w_wait_inc = 1'b1;
          end
        end else begin
          w_ctrl       = w_issue_ctrl;
          w_stall      = w_issue_stall;
          w_next_state = ST_RUN;
        end
      end

      ST_HALT: begin
        w_ctrl = CTRL_FREEZE;
      end
    endcase

    if (rst) begin
      w_ctrl = CTRL_ALL_RST;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Boot counter: counts the reset-hold cycles spent in BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_cnt <= 4'd0;
    end else if (r_state == ST_BOOT) begin
      r_boot_cnt <= r_boot_cnt + 4'd1;
    end
  end

  // Wait counter: number of stalled memory cycles of the current access,
  // the RUN cycle that first saw the stall included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if (w_wait_start) begin
      r_wait_cnt <= 8'd1;
    end else if (w_wait_inc) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != STALL_SAT)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign if_en   = w_ctrl.en[B_IF];
  assign id_en   = w_ctrl.en[B_ID];
  assign exe_en  = w_ctrl.en[B_EXE];
  assign mem_en  = w_ctrl.en[B_MEM];
  assign wb_en   = w_ctrl.en[B_WB];
  assign if_rst  = w_ctrl.rst[B_IF];
  assign id_rst  = w_ctrl.rst[B_ID];
  assign exe_rst = w_ctrl.rst[B_EXE];
  assign mem_rst = w_ctrl.rst[B_MEM];
  assign wb_rst  = w_ctrl.rst[B_WB];

  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign ctrl_state  = r_state;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Testbench for pipe_stage_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared with a behavioural model of the pipeline
// sequencing rules (phase, cycles waited, stall tally).
module tb_pipe_stage_ctrl;

  localparam int BOOT_CYCLES  = 4;
  localparam int MEM_WAIT_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0, mem_ack = 1'b0;
  logic        load_use_hazard = 1'b0, branch_taken = 1'b0;
  logic        debug_en = 1'b0, debug_step = 1'b0;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [1:0]  ctrl_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: phase uses the published ctrl_state numbering.
  int m_phase     = 0;
  int m_boot_seen = 0;
  int m_waited    = 0;
  int m_stalls    = 0;
  bit m_timeout   = 1'b0;

  pipe_stage_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .debug_en(debug_en), .debug_step(debug_step),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // {en[if,id,exe,mem,wb], rst[if,id,exe,mem,wb]}
  localparam logic [9:0] P_ALL_RST  = {5'b00000, 5'b11111};
  localparam logic [9:0] P_FREEZE   = {5'b00000, 5'b00000};
  localparam logic [9:0] P_ADVANCE  = {5'b11111, 5'b00000};
  localparam logic [9:0] P_WAIT     = {5'b00001, 5'b00001};
  localparam logic [9:0] P_LOADUSE  = {5'b00111, 5'b00100};
  localparam logic [9:0] P_BRANCH   = {5'b11111, 5'b01000};

  function automatic logic [9:0] model_issue();
    if (load_use_hazard) return P_LOADUSE;
    if (branch_taken)    return P_BRANCH;
    return P_ADVANCE;
  endfunction

  function automatic logic [9:0] model_stage();
    if (rst) return P_ALL_RST;
    case (m_phase)
      0: return P_ALL_RST;
      1: begin
        if (mem_req && !mem_ack)    return P_WAIT;
        if (debug_en && !debug_step) return P_FREEZE;
        return model_issue();
      end
      2: return mem_ack ? model_issue() : P_WAIT;
      default: return P_FREEZE;
    endcase
  endfunction

  function automatic bit model_is_stall();
    case (m_phase)
      1: return (mem_req && !mem_ack) || (!(debug_en && !debug_step) && load_use_hazard);
      2: return !mem_ack || load_use_hazard;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_phase = 0; m_boot_seen = 0; m_waited = 0; m_stalls = 0; m_timeout = 1'b0;
      return;
    end
    if (model_is_stall() && m_stalls < 65535) m_stalls++;
    case (m_phase)
      0: begin
        m_boot_seen++;
        if (m_boot_seen == BOOT_CYCLES) m_phase = 1;
      end
      1: if (mem_req && !mem_ack) begin m_phase = 2; m_waited = 1; end
      2: begin
        if (!mem_ack) begin
          if (m_waited == MEM_WAIT_MAX) begin m_timeout = 1'b1; m_phase = 3; end
          else m_waited++;
        end else m_phase = 1;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [9:0] got_stage();
    return {if_en, id_en, exe_en, mem_en, wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst};
  endfunction

  function automatic logic [28:0] got_all();
    return {got_stage(), ctrl_state, mem_timeout, stall_cnt};
  endfunction

  function automatic logic [28:0] want_all();
    return {model_stage(), 2'(m_phase), m_timeout, 16'(m_stalls)};
  endfunction

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic mr, input logic ma, input logic lu,
                       input logic bt, input logic de, input logic ds);
    @(negedge clk);
    rst = r; mem_req = mr; mem_ack = ma; load_use_hazard = lu;
    branch_taken = bt; debug_en = de; debug_step = ds;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 0, 0);
      n_cmp++;
      if (got_all() !== want_all()) begin
        n_bad++; $display("FAIL reset cyc=%0d got=%h want=%h", i, got_all(), want_all());
      end
      n_cmp++;
      if (got_all() !== {P_ALL_RST, 2'd0, 1'b0, 16'd0}) begin
        n_bad++; $display("FAIL reset_const cyc=%0d got=%h", i, got_all());
      end
      tick();
    end
  endtask

  task automatic test_boot();
    for (int i = 1; i <= BOOT_CYCLES + 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (got_all() !== want_all()) begin
        n_bad++; $display("FAIL boot cyc=%0d got=%h want=%h", i, got_all(), want_all());
      end
      n_cmp++;
      if (i <= BOOT_CYCLES) begin
        if ({got_stage(), ctrl_state} !== {P_ALL_RST, 2'd0}) begin
          n_bad++; $display("FAIL boot_hold cyc=%0d got=%h", i, {got_stage(), ctrl_state});
        end
      end else if ({got_stage(), ctrl_state} !== {P_ADVANCE, 2'd1}) begin
        n_bad++; $display("FAIL boot_release got=%h want=%h", {got_stage(), ctrl_state}, {P_ADVANCE, 2'd1});
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    drive(0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (got_stage() !== P_LOADUSE) begin
      n_bad++; $display("FAIL load_use got=%h want=%h", got_stage(), P_LOADUSE);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({got_stage(), stall_cnt} !== {P_ADVANCE, 16'd1}) begin
      n_bad++; $display("FAIL load_use_after got=%h want=%h", {got_stage(), stall_cnt}, {P_ADVANCE, 16'd1});
    end
    tick();
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (got_stage() !== P_LOADUSE) begin
      n_bad++; $display("FAIL branch_lu got=%h want=%h", got_stage(), P_LOADUSE);
    end
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (got_stage() !== P_BRANCH) begin
      n_bad++; $display("FAIL branch got=%h want=%h", got_stage(), P_BRANCH);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int base;
    logic [9:0] exp [3];
    exp = '{P_WAIT, P_WAIT, P_ADVANCE};
    base = m_stalls;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i == 2), 0, 0, 0, 0);
      n_cmp++;
      if (got_stage() !== exp[i]) begin
        n_bad++; $display("FAIL mem_wait cyc=%0d got=%h want=%h", i, got_stage(), exp[i]);
      end
      n_cmp++;
      if (got_all() !== want_all()) begin
        n_bad++; $display("FAIL mem_wait_model cyc=%0d got=%h want=%h", i, got_all(), want_all());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({stall_cnt, mem_timeout, ctrl_state} !== {16'(base + 2), 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL mem_wait_end got=%h want=%h",
                        {stall_cnt, mem_timeout, ctrl_state}, {16'(base + 2), 1'b0, 2'd1});
    end
    tick();
  endtask

  task automatic test_single_step();
    int en_cycles = 0;
    int base;
    base = m_stalls;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i == 1 || i == 4 || i == 7));
      if (got_stage()[9:5] === 5'b11111) en_cycles++;
      n_cmp++;
      if (got_all() !== want_all()) begin
        n_bad++; $display("FAIL step cyc=%0d got=%h want=%h", i, got_all(), want_all());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (en_cycles != 3 || stall_cnt !== 16'(base)) begin
      n_bad++; $display("FAIL step_count en_cycles=%0d stall=%0d want 3 and %0d", en_cycles, stall_cnt, base);
    end
    tick();
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < MEM_WAIT_MAX + 1; i++) begin
      drive(0, 1, 0, 0, 0, (i == 3), 0);
      n_cmp++;
      if ({got_stage(), mem_timeout} !== {P_WAIT, 1'b0}) begin
        n_bad++; $display("FAIL timeout_wait cyc=%0d got=%h want=%h", i, {got_stage(), mem_timeout}, {P_WAIT, 1'b0});
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i == 1), 1, 1, 0, 0);
      n_cmp++;
      if ({got_stage(), ctrl_state, mem_timeout, stall_cnt} !== {P_FREEZE, 2'd3, 1'b1, 16'(MEM_WAIT_MAX + 1)}) begin
        n_bad++; $display("FAIL timeout_halt cyc=%0d got=%h want=%h", i,
                          {got_stage(), ctrl_state, mem_timeout, stall_cnt},
                          {P_FREEZE, 2'd3, 1'b1, 16'(MEM_WAIT_MAX + 1)});
      end
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got_stage() !== P_ALL_RST) begin
      n_bad++; $display("FAIL timeout_rst got=%h want=%h", got_stage(), P_ALL_RST);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({ctrl_state, mem_timeout} !== {2'd0, 1'b0}) begin
      n_bad++; $display("FAIL timeout_clear got=%h want=%h", {ctrl_state, mem_timeout}, {2'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_random();
    int ack_pct = 50;
    int halt_len = 0;
    logic de = 1'b0;
    logic r;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ack_pct = (i / 200) % 3 == 0 ? 80 : ((i / 200) % 3 == 1 ? 50 : 10);
      if ($urandom_range(0, 49) == 0) de = ~de;
      halt_len = (m_phase == 3) ? halt_len + 1 : 0;
      r = ($urandom_range(0, 299) == 0) || (halt_len > 20);
      drive(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < ack_pct),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            de, ($urandom_range(0, 2) == 0));
      n_cmp++;
      if (got_all() !== want_all()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, got_all(), want_all());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_single_step();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
